// File: rtl/sram_port_arb.sv
// sram_port_arb
//   Shares one single-port, word-wide SRAM between the debug module (dm),
//   the load/store unit (ex) and instruction fetch (pc). Each requester
//   uses a req/gnt/rvalid handshake. Grants are combinational, and read
//   data returns exactly one cycle after the grant.
//
// Optional feature, enabled by the macro SRAM_ARB_STARVE_EN:
//   A saturating starvation counter promotes pc to top priority after
//   STARVE_LIMIT consecutive denied cycles. Without the macro, priority is
//   strictly dm > ex > pc.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   dm_req_i/we_i/addr_i/wdata_i, dm_gnt_o/rvalid_o/rdata_o   debug port
//   ex_req_i/we_i/addr_i/wdata_i, ex_gnt_o/rvalid_o/rdata_o   load/store port
//   pc_req_i/addr_i, pc_gnt_o/rvalid_o/rdata_o                fetch port (read-only)
//   mem_en_o/we_o/addr_o/wdata_o, mem_rdata_i                 SRAM macro command port
module sram_port_arb #(
   parameter int ADDR_W       = 12,
   parameter int DEPTH        = 4096,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [31:0]       dm_addr_i,
   input  logic [31:0]       dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_rvalid_o,
   output logic [31:0]       dm_rdata_o,
   input  logic              ex_req_i,
   input  logic              ex_we_i,
   input  logic [31:0]       ex_addr_i,
   input  logic [31:0]       ex_wdata_i,
   output logic              ex_gnt_o,
   output logic              ex_rvalid_o,
   output logic [31:0]       ex_rdata_o,
   input  logic              pc_req_i,
   input  logic [31:0]       pc_addr_i,
   output logic              pc_gnt_o,
   output logic              pc_rvalid_o,
   output logic [31:0]       pc_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [1:0] {RSP_NONE, RSP_DM, RSP_EX, RSP_PC} rsp_e;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam logic [33:0] BYTE_LIM = 34'(DEPTH) << 2;

   rsp_e        rsp_q, rsp_d;
   logic        oor_q, oor_d;
   logic        pc_force;

   logic        dm_gnt, ex_gnt, pc_gnt;
   logic        sel_vld, sel_we, sel_in_range;
   logic [31:0] sel_addr, sel_wdata;
   rsp_e        sel_owner;
   logic [31:0] rsp_data;

`ifdef SRAM_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q, starve_d;

   // Promotion needs a live pc request so dm/ex are never blocked for nothing.
   assign pc_force = pc_req_i && (starve_q == SW'(STARVE_LIMIT));

   always_comb begin
      starve_d = starve_q;
      if (rst || !pc_req_i || pc_gnt)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk) starve_q <= starve_d;
`else
   assign pc_force = 1'b0;
`endif

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      dm_gnt = 1'b0;
      ex_gnt = 1'b0;
      pc_gnt = 1'b0;
      if (!rst) begin
         if (pc_force)      pc_gnt = 1'b1;
         else if (dm_req_i) dm_gnt = 1'b1;
         else if (ex_req_i) ex_gnt = 1'b1;
         else if (pc_req_i) pc_gnt = 1'b1;
      end
   end

   // Mux the winning request onto a single command.
   always_comb begin
      sel_vld   = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_owner = RSP_NONE;
      if (dm_gnt) begin
         sel_vld = 1'b1; sel_we = dm_we_i; sel_addr = dm_addr_i;
         sel_wdata = dm_wdata_i; sel_owner = RSP_DM;
      end else if (ex_gnt) begin
         sel_vld = 1'b1; sel_we = ex_we_i; sel_addr = ex_addr_i;
         sel_wdata = ex_wdata_i; sel_owner = RSP_EX;
      end else if (pc_gnt) begin
         sel_vld = 1'b1; sel_addr = pc_addr_i; sel_owner = RSP_PC;
      end
   end

   assign sel_in_range = ({2'b00, sel_addr} < BYTE_LIM);

   // Out-of-range accesses are granted but never reach the macro.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (sel_vld && sel_in_range) begin
         mem_en_o    = 1'b1;
         mem_we_o    = sel_we;
         mem_addr_o  = sel_addr[ADDR_W+1:2];
         mem_wdata_o = sel_wdata;
      end
   end

   // Response owner tracks the read granted this cycle; writes leave it NONE.
   always_comb begin
      rsp_d = RSP_NONE;
      oor_d = 1'b0;
      if (!rst && sel_vld && !sel_we) begin
         rsp_d = sel_owner;
         oor_d = !sel_in_range;
      end
   end

   always_ff @(posedge clk) begin
      rsp_q <= rsp_d;
      oor_q <= oor_d;
   end

   always_comb begin
      rsp_data = mem_rdata_i;
      if (oor_q) rsp_data = (rsp_q == RSP_PC) ? NOP_INSN : 32'h0;
   end

   always_comb begin
      dm_gnt_o    = dm_gnt;
      ex_gnt_o    = ex_gnt;
      pc_gnt_o    = pc_gnt;
      dm_rvalid_o = !rst && (rsp_q == RSP_DM);
      ex_rvalid_o = !rst && (rsp_q == RSP_EX);
      pc_rvalid_o = !rst && (rsp_q == RSP_PC);
      dm_rdata_o  = dm_rvalid_o ? rsp_data : 32'h0;
      ex_rdata_o  = ex_rvalid_o ? rsp_data : 32'h0;
      pc_rdata_o  = pc_rvalid_o ? rsp_data : 32'h0;
   end

endmodule
